// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin 2:1 mux select block:
// FSM state encoding and default parameter values.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEF = 4;
    localparam int CNT_W_DEF    = 3;

endpackage

// File: rtl/hold_counter.sv
// Counts consecutive cycles a grant has been held; saturates at MAX_HOLD-1
// so it never wraps, and flags that limit through at_max.
module hold_counter
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    logic [CNT_W-1:0] r_cnt;

    assign at_max = (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && !at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_sel.sv
// Round-robin select generator for a downstream 2:1 mux with a per-grant
// hold limit and per-channel early release.
module mux_rr_sel
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       rel,
    output logic             s,
    output logic [1:0]       gnt,
    output logic             valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [1:0]       dbg_state
);

    state_t r_state;
    logic   r_s;
    logic   r_last_gnt;

    state_t w_next;
    logic   w_end;
    logic   w_at_max;
    logic   w_clr;
    logic   w_en;

    // A grant ends on request drop, release or hold expiry; the other
    // channel takes over directly, otherwise an expired holder is re-granted.
    always_comb begin
        w_next = r_state;
        w_end  = 1'b0;
        case (r_state)
            IDLE: begin
                case (req)
                    2'b01:   w_next = GRANT0;
                    2'b10:   w_next = GRANT1;
                    2'b11:   w_next = r_last_gnt ? GRANT0 : GRANT1;
                    default: w_next = IDLE;
                endcase
            end
            GRANT0: begin
                w_end = !req[0] || rel[0] || w_at_max;
                if (w_end) begin
                    if (req[1])                 w_next = GRANT1;
                    else if (req[0] && !rel[0]) w_next = GRANT0;
                    else                        w_next = IDLE;
                end
            end
            GRANT1: begin
                w_end = !req[1] || rel[1] || w_at_max;
                if (w_end) begin
                    if (req[0])                 w_next = GRANT0;
                    else if (req[1] && !rel[1]) w_next = GRANT1;
                    else                        w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_clr = w_end || (r_state == IDLE);
    assign w_en  = (r_state != IDLE) && !w_end;

    hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_en),
        .cnt    (hold_cnt),
        .at_max (w_at_max)
    );

    // s only moves on entry to a grant, so it holds its value through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_s        <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == GRANT0) begin
                r_s        <= 1'b0;
                r_last_gnt <= 1'b0;
            end else if (w_next == GRANT1) begin
                r_s        <= 1'b1;
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign gnt       = {r_state == GRANT1, r_state == GRANT0};
    assign valid     = (r_state == GRANT0) || (r_state == GRANT1);
    assign s         = r_s;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed scoreboard bench for mux_rr_sel (MAX_HOLD=4, CNT_W=3).
module tb_mux_rr_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] rel = 2'b00;
    logic       s;
    logic [1:0] gnt;
    logic       valid;
    logic [2:0] hold_cnt;
    logic [1:0] dbg_state;

    // Expected word: {gnt[1:0], s, valid, hold_cnt[2:0]}
    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       stim_done = 1'b0;

    mux_rr_sel #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .s         (s),
        .gnt       (gnt),
        .valid     (valid),
        .hold_cnt  (hold_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge and queue the outputs expected after it.
    task automatic step(input logic r, input logic [1:0] q, input logic [1:0] l,
                        input logic [1:0] e_gnt, input logic e_s, input logic [2:0] e_cnt);
        @(negedge clk);
        rst = r;
        req = q;
        rel = l;
        exp_q.push_back({e_gnt, e_s, (e_gnt != 2'b00), e_cnt});
    endtask

    // Monitor: every post-edge sample is compared against the queue head.
    initial begin
        logic [6:0] exp_v;
        logic [6:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {gnt, s, valid, hold_cnt};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL check%0d t=%0t: got gnt=%b s=%b valid=%b cnt=%0d, expected gnt=%b s=%b valid=%b cnt=%0d",
                             n_checks, $time, act_v[6:5], act_v[4], act_v[3], act_v[2:0],
                             exp_v[6:5], exp_v[4], exp_v[3], exp_v[2:0]);
                end
            end
        end
    end

    initial begin
        // Reset, then idle with no requests
        step(1, 2'b00, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 2'b00, 0, 0);

        // Single requester: grant, count 0..3, re-grant at expiry, then drop
        step(0, 2'b01, 2'b00, 2'b01, 0, 0);
        step(0, 2'b01, 2'b00, 2'b01, 0, 1);
        step(0, 2'b01, 2'b00, 2'b01, 0, 2);
        step(0, 2'b01, 2'b00, 2'b01, 0, 3);
        step(0, 2'b01, 2'b00, 2'b01, 0, 0);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0);

        // Both requesting from reset: channel 0 first, alternate every 4 cycles
        step(1, 2'b11, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 2'b11, 2'b00, 2'b01, 0, 3'(i));
        for (int i = 0; i < 4; i++) step(0, 2'b11, 2'b00, 2'b10, 1, 3'(i));
        step(0, 2'b11, 2'b00, 2'b01, 0, 0);

        // Release on non-granted channel is ignored; release on holder hands over
        step(0, 2'b11, 2'b00, 2'b01, 0, 1);
        step(0, 2'b11, 2'b00, 2'b01, 0, 2);
        step(0, 2'b11, 2'b00, 2'b01, 0, 3);
        step(0, 2'b11, 2'b00, 2'b10, 1, 0);
        step(0, 2'b11, 2'b01, 2'b10, 1, 1);
        step(0, 2'b11, 2'b10, 2'b01, 0, 0);

        // Reset mid-grant at hold_cnt=2, then tie goes to channel 0
        step(0, 2'b11, 2'b00, 2'b01, 0, 1);
        step(0, 2'b11, 2'b00, 2'b01, 0, 2);
        step(1, 2'b11, 2'b00, 2'b00, 0, 0);
        step(0, 2'b11, 2'b00, 2'b01, 0, 0);

        // Holder drops, other takes over without gap; s holds through IDLE
        step(0, 2'b10, 2'b00, 2'b10, 1, 0);
        step(0, 2'b00, 2'b00, 2'b00, 1, 0);
        step(0, 2'b00, 2'b00, 2'b00, 1, 0);
        step(0, 2'b10, 2'b00, 2'b10, 1, 0);
        // req and rel dropped together: one end-of-grant
        step(0, 2'b00, 2'b10, 2'b00, 1, 0);
        // Tie after last grant to channel 1 goes to channel 0
        step(0, 2'b11, 2'b00, 2'b01, 0, 0);
        step(0, 2'b01, 2'b10, 2'b01, 0, 1);

        stim_done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_sel.md
MUX_RR_SEL -- requirements
Module: mux_rr_sel

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one channel may hold a grant (legal range 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of the hold counter (2^CNT_W > MAX_HOLD).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 2, per-channel requests to drive the downstream 2:1 mux (bit k = in[k]).
REQ-006 The block SHALL have port rel, input, 2, per-channel early release; it is ignored unless that channel holds the grant.
REQ-007 The block SHALL have port s, output, 1, the registered select for the downstream mux (0 selects in[0], 1 selects in[1]).
REQ-008 The block SHALL have port gnt, output, 2, a registered grant that is one-hot or 00.
REQ-009 The block SHALL have port valid, output, 1, asserted high exactly when gnt is not 00.
REQ-010 The block SHALL have port hold_cnt, output, CNT_W, the number of cycles the current grant has been held, starting at 0.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, GRANT0 and GRANT1; gnt, s and valid are decoded from registered state only.
REQ-012 In IDLE, a single active req[k] SHALL cause a move to GRANTk on the next edge, giving one cycle of latency from req to gnt.
REQ-013 In IDLE with req=11, the block SHALL grant the channel that is not last_gnt (round-robin pointer).
REQ-014 In GRANTk, hold_cnt SHALL increment by 1 each cycle that the block stays in GRANTk.
REQ-015 In GRANTk, the grant SHALL end on the edge where any of these holds: req[k]=0, rel[k]=1, or hold_cnt=MAX_HOLD-1.
REQ-016 When a grant ends and req[other]=1, the block SHALL go directly to GRANTother with no IDLE bubble, and hold_cnt SHALL become 0.
REQ-017 When a grant ends by hold expiry and only req[k]=1, the block SHALL re-grant GRANTk with hold_cnt=0 (no starvation while the other channel is idle).
REQ-018 When a grant ends and neither channel is requesting, the block SHALL go to IDLE with hold_cnt=0.
REQ-019 On every entry to GRANTk, last_gnt SHALL be set to k.
REQ-020 In IDLE, s SHALL hold its last value, so the mux select never toggles without a grant change.
REQ-021 When rel[k] and req[k] are both dropped in the same cycle, this SHALL count as a single end-of-grant event.
REQ-022 A rel on the non-granted channel SHALL have no effect.
REQ-023 hold_cnt SHALL never exceed MAX_HOLD-1 and SHALL never wrap.
REQ-024 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and with req=11 the grants SHALL alternate every cycle.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set state=IDLE, s=0, gnt=00, valid=0, hold_cnt=0 and last_gnt=1, so channel 0 wins the first tie.
REQ-026 A reset asserted mid-grant SHALL take effect at the next edge regardless of req and rel, and no grant SHALL be issued in that same cycle.
REQ-027 On the first edge after rst deasserts, the block SHALL sample req as if it were in IDLE.

Structure
REQ-028 A shared package mux_sel_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the default values of MAX_HOLD and CNT_W.
REQ-029 The hold counter SHALL be a sub-module hold_counter (ports: clk, rst, clr, en, cnt, at_max) instantiated once.
REQ-030 All other logic SHALL be in mux_rr_sel.

Verification
REQ-031 A bench SHALL apply a reset, then hold req=00 for 3 cycles, and check s=0, gnt=00, valid=0 and hold_cnt=0 throughout.
REQ-032 A bench SHALL apply req=01 at cycle 0 and check gnt=01 and s=0 at cycle 1, then hold_cnt=0,1,2,3, then a re-grant with hold_cnt=0 at cycle 5 (MAX_HOLD=4).
REQ-033 A bench SHALL apply req=11 from reset and check gnt=01 for 4 cycles, then gnt=10 with s=1 for 4 cycles, alternating with no valid=0 gap.
REQ-034 A bench SHALL, during GRANT1 at hold_cnt=1, pulse rel=10 with req=11, and check gnt=01 on the next cycle; a separate rel=01 pulse during GRANT1 SHALL show no effect.
REQ-035 A bench SHALL, during GRANT0 at hold_cnt=2, assert rst for 1 cycle, and check gnt=00, s=0 and hold_cnt=0 on the next cycle, then gnt=01 one cycle after rst drops with req=11.
